store_queue: RTL
================

STORE_QUEUE -- requirements
Module: store_queue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4: number of store entries; power of two, >=2.
REQ-002 The block SHALL have parameter BIG_ENDIAN, default 1: 1 = MIPS big-endian lane mapping; 0 = little-endian mapping.
REQ-003 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-004 The block SHALL have these ports (name, direction, width, meaning):
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- req_valid  in  1  store request present.
- req_ready  out  1  queue can accept a request.
- req_op  in  3  instruction[28:26]: 000 SB, 001 SH, 010 SWL, 011 SW, 110 SWR.
- req_addr  in  32  byte address.
- req_data  in  32  rt register value.
- avm_address  out  32  word-aligned write address.
- avm_write  out  1  write strobe.
- avm_writedata  out  32  lane-formatted data.
- avm_byteenable  out  4  lane enables.
- avm_waitrequest  in  1  slave stall.
- empty  out  1  no entries.
- full  out  1  DEPTH entries held.
- count  out  $clog2(DEPTH+1)  occupancy.
- err  out  1  one-cycle pulse on a rejected request.

Function
REQ-005 The block SHALL map byte offset k = req_addr[1:0] to lane k (bits 8k+7:8k, byteenable[k]) and drive 0 on disabled lanes.
REQ-006 With BIG_ENDIAN=1 the block SHALL format lanes as follows:
- SB: lane k = rt[7:0].
- SH: lane k = rt[15:8], lane k+1 = rt[7:0].
- SW: lanes 0..3 = rt[31:24], rt[23:16], rt[15:8], rt[7:0].
- SWL: lane k+i = rt byte (3-i) for i = 0..3-k.
- SWR: lane k-i = rt byte i for i = 0..k.
REQ-007 With BIG_ENDIAN=0 the block SHALL use the natural mapping (SH lane k = rt[7:0], SW writedata = rt) and SHALL treat SWL/SWR as illegal.
REQ-008 The block SHALL reject without enqueuing, and pulse err for one cycle, when the request is:
- SH with addr[0]=1;
- SW with addr[1:0]!=0;
- any unlisted opcode.
REQ-009 The block SHALL assert req_ready = !full; a request SHALL enqueue when req_valid && req_ready && legal.
REQ-010 The block SHALL store each entry as {addr[31:2], formatted data, byteenable} and drain entries in FIFO order.
REQ-011 Bus output SHALL behave as follows:
- avm_write = !empty.
- avm_address/writedata/byteenable are taken from the head entry, with avm_address = {addr[31:2], 2'b00}.
- These outputs SHALL be held stable while avm_waitrequest=1.
REQ-012 The block SHALL dequeue the head entry when avm_write && !avm_waitrequest.
REQ-013 The block SHALL assert avm_write on the first clock edge after an enqueue into an empty queue (latency 1); empty-queue bypass is forbidden.
REQ-014 On a simultaneous enqueue and dequeue, count SHALL be unchanged and both pointers SHALL advance.
REQ-015 When full, the block SHALL ignore a request even if a dequeue occurs in the same cycle.
REQ-016 Read and write pointers SHALL wrap modulo DEPTH; count SHALL never exceed DEPTH or underflow.
REQ-017 The empty, full and count outputs SHALL be registered and consistent with each other in every cycle.

Reset
REQ-018 While reset_n=0 the block SHALL hold:
- pointers=0, count=0, empty=1, full=0;
- avm_write=0, avm_address=0, avm_writedata=0, avm_byteenable=0;
- err=0.
REQ-019 Reset asserted mid-operation SHALL discard all pending entries, including one stalled by waitrequest.

Structure
REQ-020 The shared package store_pkg SHALL hold:
- opcode localparams OP_SB, OP_SH, OP_SWL, OP_SW, OP_SWR;
- typedef store_entry_t {addr_word[29:0], data[31:0], be[3:0]}.
REQ-021 Lane formatting SHALL be a combinational sub-module, store_lane_format, with inputs op, offset and rt and outputs data, be and illegal; the queue SHALL instantiate it once.

Verification
REQ-022 The bench SHALL cover these directed scenarios (BIG_ENDIAN=1, DEPTH=4, waitrequest=0 unless stated):
- SB addr 0x1003 data 0x000000AB -> avm_address 0x1000, byteenable 1000, writedata 0xAB000000, one cycle after accept.
- SH addr 0x2002 data 0x0000BEEF -> byteenable 1100, writedata 0xEFBE0000; SW addr 0x2000 data 0x12345678 -> byteenable 1111, writedata 0x78563412.
- SWL addr 0x3001 data 0x11223344 -> byteenable 1110, writedata 0x33221100; SWR addr 0x3001 -> byteenable 0011, writedata 0x00004433.
- SH addr 0x2001 -> err pulse, count unchanged, no bus write.
- waitrequest held 1, five back-to-back requests -> req_ready low after the fourth, count=4, full=1, outputs stable; release -> four writes in order on consecutive cycles, then empty=1.
- reset_n low while full and stalled -> avm_write=0, count=0 asynchronously; no write after release.

Source files
------------

// File: rtl/store_pkg.sv
// Shared definitions for the store queue: MIPS store opcodes and the queued entry layout.
package store_pkg;

    localparam logic [2:0] OP_SB  = 3'b000;
    localparam logic [2:0] OP_SH  = 3'b001;
    localparam logic [2:0] OP_SWL = 3'b010;
    localparam logic [2:0] OP_SW  = 3'b011;
    localparam logic [2:0] OP_SWR = 3'b110;

    typedef struct packed {
        logic [29:0] addr_word;
        logic [31:0] data;
        logic [3:0]  be;
    } store_entry_t;

    function automatic logic [7:0] rt_byte(input logic [31:0] rt, input logic [1:0] idx);
        return rt[{idx, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/store_lane_format.sv
// Combinational byte-lane steering for SB/SH/SW/SWL/SWR; flags misaligned or unknown stores.
module store_lane_format
    import store_pkg::*;
#(
    parameter bit BIG_ENDIAN = 1'b1
) (
    input  logic [2:0]  op,
    input  logic [1:0]  offset,
    input  logic [31:0] rt,
    output logic [31:0] data,
    output logic [3:0]  be,
    output logic        illegal
);

    logic [1:0] lane;
    logic [1:0] src;
    logic       en;

    always_comb begin
        data    = '0;
        be      = '0;
        lane    = '0;
        src     = '0;
        en      = 1'b0;
        case (op)
            OP_SB:          illegal = 1'b0;
            OP_SH:          illegal = offset[0];
            OP_SW:          illegal = (offset != 2'd0);
            OP_SWL, OP_SWR: illegal = !BIG_ENDIAN;
            default:        illegal = 1'b1;
        endcase
        // Per lane: decide whether it is written and which rt byte feeds it.
        for (int j = 0; j < 4; j++) begin
            lane = 2'(j);
            en   = 1'b0;
            src  = 2'd0;
            case (op)
                OP_SB: begin
                    en  = (lane == offset);
                    src = 2'd0;
                end
                OP_SH: begin
                    en  = (lane == offset) || (lane == 2'(offset + 2'd1));
                    src = ((lane == offset) == BIG_ENDIAN) ? 2'd1 : 2'd0;
                end
                OP_SW: begin
                    en  = 1'b1;
                    src = BIG_ENDIAN ? ~lane : lane;
                end
                OP_SWL: begin
                    en  = (lane >= offset);
                    src = 2'(offset + ~lane);
                end
                OP_SWR: begin
                    en  = (lane <= offset);
                    src = 2'(offset - lane);
                end
                default: en = 1'b0;
            endcase
            if (en && !illegal) begin
                be[j]          = 1'b1;
                data[8*j +: 8] = rt_byte(rt, src);
            end
        end
    end

endmodule

// File: rtl/store_queue.sv
// FIFO of formatted stores draining to an Avalon-MM write master; no empty-queue bypass.
module store_queue
    import store_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter bit BIG_ENDIAN = 1'b1
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [2:0]                 req_op,
    input  logic [31:0]                req_addr,
    input  logic [31:0]                req_data,
    output logic [31:0]                avm_address,
    output logic                       avm_write,
    output logic [31:0]                avm_writedata,
    output logic [3:0]                 avm_byteenable,
    input  logic                       avm_waitrequest,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       err
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    store_entry_t  mem [DEPTH];
    store_entry_t  head;
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] cnt_nxt;
    logic [31:0]   fmt_data;
    logic [3:0]    fmt_be;
    logic          illegal;
    logic          enq, deq;

    store_lane_format #(.BIG_ENDIAN(BIG_ENDIAN)) u_fmt (
        .op      (req_op),
        .offset  (req_addr[1:0]),
        .rt      (req_data),
        .data    (fmt_data),
        .be      (fmt_be),
        .illegal (illegal)
    );

    // full is registered, so a dequeue in the same cycle never opens a slot early.
    assign req_ready = !full;
    assign enq       = req_valid && !full && !illegal;
    assign deq       = !empty && !avm_waitrequest;

    always_comb begin
        cnt_nxt = count;
        case ({enq, deq})
            2'b10:   cnt_nxt = count + CW'(1);
            2'b01:   cnt_nxt = count - CW'(1);
            default: cnt_nxt = count;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            empty  <= 1'b1;
            full   <= 1'b0;
            err    <= 1'b0;
        end else begin
            if (enq) wr_ptr <= wr_ptr + PW'(1);
            if (deq) rd_ptr <= rd_ptr + PW'(1);
            count <= cnt_nxt;
            empty <= (cnt_nxt == '0);
            full  <= (cnt_nxt == CW'(DEPTH));
            err   <= req_valid && !full && illegal;
        end
    end

    always_ff @(posedge clk) begin
        if (enq) mem[wr_ptr] <= {req_addr[31:2], fmt_data, fmt_be};
    end

    // Bus fields are zeroed while empty so stale storage never shows on the bus.
    assign head           = mem[rd_ptr];
    assign avm_write      = !empty;
    assign avm_address    = empty ? '0 : {head.addr_word, 2'b00};
    assign avm_writedata  = empty ? '0 : head.data;
    assign avm_byteenable = empty ? '0 : head.be;

endmodule
